mem_stage_ctrl: RTL and testbench

- Sequences the MEM stage of the 5-stage RV32 pipeline.
- Consumes the instruction held in the MEM pipeline register and issues load/store requests on the data-memory handshake interface.
- Aligns and extends load data, then hands one result per instruction to the WB pipeline register.
- Drives the MEM register's ready, so that register holds its contents while a memory access is outstanding.

---
 rtl/mem_stage_ctrl_pkg.sv | 42 ++++
 rtl/mem_stage_ctrl_lane_align.sv | 58 +++++
 rtl/mem_stage_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller: instruction-type bit
// positions, funct3 encodings, FSM state encoding and a helper that says
// whether a non-memory instruction type writes its destination register.
package mem_stage_ctrl_pkg;

   // Bit positions inside the one-hot instr_type vector
   localparam int T_R      = 0;
   localparam int T_I      = 1;
   localparam int T_LOAD   = 2;
   localparam int T_STORE  = 3;
   localparam int T_BRANCH = 4;
   localparam int T_JAL    = 5;
   localparam int T_JALR   = 6;
   localparam int T_U      = 7;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   // Controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RD_WAIT = 2'd2
   } state_t;

   // Stores and branches never write the register file; every other valid
   // type does. Written as "any bit set, but not those two" so every bit of
   // the type vector participates.
   function automatic logic writes_rd(input logic [7:0] t);
      return (|t) & ~t[T_STORE] & ~t[T_BRANCH];
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_lane_align.sv
// Combinational byte-lane logic for the MEM stage: store strobe / data
// replication from the latched address and funct3, and extraction plus
// sign/zero extension of returned load data.
module mem_lane_align
   import mem_stage_ctrl_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wd,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_strb,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Store lanes: replicate the narrow value across the word, enable its lanes
   always_comb begin
      o_strb  = 4'b1111;
      o_wdata = i_wd;
      case (i_funct3)
         F3_SB: begin
            o_strb  = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wd[7:0]}};
         end
         F3_SH: begin
            o_strb  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wd[15:0]}};
         end
         default: begin
            o_strb  = 4'b1111;
            o_wdata = i_wd;
         end
      endcase
   end

   // Load extract: byte picked by addr[1:0]; halves use addr[1] only (no trap)
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_funct3)
         F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_LBU:  o_load_data = {24'd0, w_byte};
         F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
         F3_LHU:  o_load_data = {16'd0, w_half};
         default: o_load_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer for the 5-stage RV32 pipeline. Non-memory results pass
// straight to the WB register; loads and stores run a REQ / RD_WAIT sequence
// on the data-memory handshake while in_ready holds the MEM register.
// Optional build macro: MEM_PERF_CNT_EN adds saturating load/store stall
// counters (load_stall_cnt, store_stall_cnt).
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. Memory requests (MemRead/MemWrite with Address, Write_data,
// Write_strb) stay asserted with stable fields until Mem_Req_Ready; load
// data transfers on Read_data_Valid & Read_data_Ready; the WB result holds
// until wb_ready; the MEM register advances on in_valid & in_ready.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int XLEN = 32
`ifdef MEM_PERF_CNT_EN
   , parameter int PERF_CNT_W = 32
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [7:0]      instr_type,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] ex_result,
   input  logic [XLEN-1:0] write_data,
   input  logic [4:0]      rd,
   output logic [XLEN-1:0] Address,
   output logic            MemWrite,
   output logic            MemRead,
   output logic [XLEN-1:0] Write_data,
   output logic [3:0]      Write_strb,
   input  logic            Mem_Req_Ready,
   input  logic [XLEN-1:0] Read_data,
   input  logic            Read_data_Valid,
   output logic            Read_data_Ready,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            wb_wen,
`ifdef MEM_PERF_CNT_EN
   output logic [PERF_CNT_W-1:0] load_stall_cnt,
   output logic [PERF_CNT_W-1:0] store_stall_cnt,
`endif
   output logic [1:0]      o_dbg_state
);

   state_t          r_state;
   logic            r_is_load;
   logic [1:0]      r_addr_lo;
   logic [2:0]      r_funct3;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_wd;
   logic [XLEN-1:0] r_addr;
   logic            r_mem_read;
   logic            r_mem_write;
   logic            r_rd_ready;
   logic            r_wb_valid;
   logic [XLEN-1:0] r_wb_data;
   logic [4:0]      r_wb_rd;
   logic            r_wb_wen;

   logic            w_wb_free;
   logic            w_is_mem;
   logic            w_accept_alu;
   logic            w_st_done;
   logic            w_ld_done;
   logic [31:0]     w_load_data;

   assign w_wb_free    = ~r_wb_valid | wb_ready;
   assign w_is_mem     = instr_type[T_LOAD] | instr_type[T_STORE];
   assign w_accept_alu = (r_state == ST_IDLE) & in_valid & w_wb_free & ~w_is_mem;
   assign w_st_done    = (r_state == ST_REQ) & ~r_is_load & Mem_Req_Ready;
   assign w_ld_done    = (r_state == ST_RD_WAIT) & Read_data_Valid;

   // The MEM register advances exactly when this instruction's result is handed off
   assign in_ready = w_accept_alu | w_st_done | w_ld_done;

   mem_lane_align u_lane (
      .i_funct3    (r_funct3),
      .i_addr_lo   (r_addr_lo),
      .i_wd        (r_wd),
      .i_rdata     (Read_data),
      .o_strb      (Write_strb),
      .o_wdata     (Write_data),
      .o_load_data (w_load_data)
   );

   // Controller FSM with registered request, load-ready and WB outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_is_load   <= 1'b0;
         r_addr_lo   <= 2'd0;
         r_funct3    <= 3'd0;
         r_rd        <= 5'd0;
         r_wd        <= '0;
         r_addr      <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_rd_ready  <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wb_data   <= '0;
         r_wb_rd     <= 5'd0;
         r_wb_wen    <= 1'b0;
      end else begin
         // Drain by default; a new result below overrides, so drain+refill keeps valid
         if (wb_ready) r_wb_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (in_valid && w_wb_free) begin
                  if (!w_is_mem) begin
                     r_wb_valid <= 1'b1;
                     r_wb_data  <= ex_result;
                     r_wb_rd    <= rd;
                     r_wb_wen   <= writes_rd(instr_type) & (rd != 5'd0);
                  end else begin
                     r_is_load   <= instr_type[T_LOAD];
                     r_addr_lo   <= ex_result[1:0];
                     r_funct3    <= funct3;
                     r_rd        <= rd;
                     r_wd        <= write_data;
                     r_addr      <= {ex_result[XLEN-1:2], 2'b00};
                     r_mem_read  <= instr_type[T_LOAD];
                     r_mem_write <= ~instr_type[T_LOAD];
                     r_state     <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (Mem_Req_Ready) begin
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  if (r_is_load) begin
                     r_rd_ready <= 1'b1;
                     r_state    <= ST_RD_WAIT;
                  end else begin
                     r_wb_valid <= 1'b1;
                     r_wb_wen   <= 1'b0;
                     r_wb_rd    <= r_rd;
                     r_state    <= ST_IDLE;
                  end
               end
            end
            ST_RD_WAIT: begin
               if (Read_data_Valid) begin
                  r_wb_valid <= 1'b1;
                  r_wb_data  <= w_load_data;
                  r_wb_rd    <= r_rd;
                  r_wb_wen   <= (r_rd != 5'd0);
                  r_rd_ready <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Address         = r_addr;
   assign MemRead         = r_mem_read;
   assign MemWrite        = r_mem_write;
   assign Read_data_Ready = r_rd_ready;
   assign wb_valid        = r_wb_valid;
   assign wb_data         = r_wb_data;
   assign wb_rd           = r_wb_rd;
   assign wb_wen          = r_wb_wen;
   assign o_dbg_state     = r_state;

`ifdef MEM_PERF_CNT_EN
   localparam logic [PERF_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [PERF_CNT_W-1:0] CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

   logic [PERF_CNT_W-1:0] r_ld_cnt;
   logic [PERF_CNT_W-1:0] r_st_cnt;

   // Saturating stall counters: cycles spent waiting on memory for loads / stores
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ld_cnt <= '0;
         r_st_cnt <= '0;
      end else begin
         if ((((r_state == ST_REQ) && r_is_load) || (r_state == ST_RD_WAIT))
             && (r_ld_cnt != CNT_MAX))
            r_ld_cnt <= r_ld_cnt + CNT_ONE;
         if ((r_state == ST_REQ) && !r_is_load && (r_st_cnt != CNT_MAX))
            r_st_cnt <= r_st_cnt + CNT_ONE;
      end
   end

   assign load_stall_cnt  = r_ld_cnt;
   assign store_stall_cnt = r_st_cnt;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a table of single-cycle ALU vectors,
// then hand sequences for stores, loads, WB back-pressure and reset mid-load.
module tb_mem_stage_ctrl;

  localparam logic [7:0] TY_R     = 8'h01;
  localparam logic [7:0] TY_I     = 8'h02;
  localparam logic [7:0] TY_LOAD  = 8'h04;
  localparam logic [7:0] TY_STORE = 8'h08;
  localparam logic [7:0] TY_BR    = 8'h10;
  localparam logic [7:0] TY_JAL   = 8'h20;
  localparam logic [7:0] TY_JALR  = 8'h40;
  localparam logic [7:0] TY_U     = 8'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  instr_type = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] ex_result = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  rd = '0;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready = 1'b0;
  logic [31:0] Read_data = '0;
  logic        Read_data_Valid = 1'b0;
  logic        Read_data_Ready;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [1:0]  dbg_state;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] load_stall_cnt;
  logic [31:0] store_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instr_type      (instr_type),
    .funct3          (funct3),
    .ex_result       (ex_result),
    .write_data      (write_data),
    .rd              (rd),
    .Address         (Address),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_data         (wb_data),
    .wb_rd           (wb_rd),
    .wb_wen          (wb_wen),
`ifdef MEM_PERF_CNT_EN
    .load_stall_cnt  (load_stall_cnt),
    .store_stall_cnt (store_stall_cnt),
`endif
    .o_dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: a store; called and returning just after a negedge
  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input int req_dly, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input string nm);
    in_valid = 1'b1; instr_type = TY_STORE; funct3 = f3; ex_result = addr;
    write_data = wd; rd = 5'd9; wb_ready = 1'b1; Mem_Req_Ready = 1'b0;
    #1 check({nm, " in_ready idle"}, in_ready, 0);
    @(negedge clk);
    write_data = ~wd;  // request fields must come from the latched copy
    for (int k = 0; k < req_dly; k++) begin
      check({nm, " MemWrite held"}, MemWrite, 1);
      check({nm, " MemRead"}, MemRead, 0);
      check({nm, " Address"}, Address, addr & 32'hFFFF_FFFC);
      check({nm, " strb"}, Write_strb, exp_strb);
      check({nm, " wdata"}, Write_data, exp_wdata);
      check({nm, " in_ready wait"}, in_ready, 0);
      @(negedge clk);
    end
    check({nm, " MemWrite accept"}, MemWrite, 1);
    Mem_Req_Ready = 1'b1;
    #1 check({nm, " in_ready accept"}, in_ready, 1);
    @(negedge clk);
    Mem_Req_Ready = 1'b0; in_valid = 1'b0;
    check({nm, " wb_valid"}, wb_valid, 1);
    check({nm, " wb_wen"}, wb_wen, 0);
    check({nm, " MemWrite drop"}, MemWrite, 0);
    check({nm, " state idle"}, dbg_state, 0);
  endtask

  // driver: a load; called and returning just after a negedge
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rdst,
                         input int req_dly, input int dat_dly, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input logic exp_wen, input string nm);
    in_valid = 1'b1; instr_type = TY_LOAD; funct3 = f3; ex_result = addr;
    rd = rdst; wb_ready = 1'b1; Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0;
    #1 check({nm, " in_ready idle"}, in_ready, 0);
    @(negedge clk);
    for (int k = 0; k < req_dly; k++) begin
      check({nm, " MemRead held"}, MemRead, 1);
      @(negedge clk);
    end
    check({nm, " MemRead"}, MemRead, 1);
    check({nm, " Address"}, Address, addr & 32'hFFFF_FFFC);
    check({nm, " MemWrite"}, MemWrite, 0);
    Mem_Req_Ready = 1'b1;
    @(negedge clk);
    Mem_Req_Ready = 1'b0;
    check({nm, " MemRead drop"}, MemRead, 0);
    check({nm, " rd_ready"}, Read_data_Ready, 1);
    for (int d = 0; d < dat_dly; d++) begin
      check({nm, " in_ready wait"}, in_ready, 0);
      @(negedge clk);
    end
    Read_data_Valid = 1'b1; Read_data = rdata;
    #1 check({nm, " in_ready done"}, in_ready, 1);
    @(negedge clk);
    Read_data_Valid = 1'b0; in_valid = 1'b0; Read_data = 32'h0;
    check({nm, " wb_valid"}, wb_valid, 1);
    check({nm, " wb_data"}, wb_data, exp_data);
    check({nm, " wb_wen"}, wb_wen, exp_wen);
    check({nm, " wb_rd"}, wb_rd, rdst);
    check({nm, " rd_ready drop"}, Read_data_Ready, 0);
  endtask

  typedef struct {
    logic [7:0]  ty;
    logic [31:0] ex;
    logic [4:0]  rdst;
    logic [31:0] exp_data;
    logic        exp_wen;
  } alu_vec_t;

  alu_vec_t vecs[6];

  initial begin
    vecs[0] = '{TY_R,    32'h0000_1234, 5'd5,  32'h0000_1234, 1'b1};
    vecs[1] = '{TY_I,    32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{TY_BR,   32'h0000_0001, 5'd7,  32'h0000_0001, 1'b0};
    vecs[3] = '{TY_JAL,  32'h0000_0104, 5'd1,  32'h0000_0104, 1'b1};
    vecs[4] = '{TY_JALR, 32'h8000_0000, 5'd31, 32'h8000_0000, 1'b1};
    vecs[5] = '{TY_U,    32'hABCD_E000, 5'd10, 32'hABCD_E000, 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    check("rst state", dbg_state, 0);
    check("rst wb_valid", wb_valid, 0);
    check("rst wb_wen", wb_wen, 0);
    check("rst wb_data", wb_data, 0);
    check("rst wb_rd", wb_rd, 0);
    check("rst MemRead", MemRead, 0);
    check("rst MemWrite", MemWrite, 0);
    check("rst rd_ready", Read_data_Ready, 0);
`ifdef MEM_PERF_CNT_EN
    check("rst ld_cnt", load_stall_cnt, 0);
    check("rst st_cnt", store_stall_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // table-driven single-cycle pass-through
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; instr_type = vecs[i].ty; ex_result = vecs[i].ex;
      rd = vecs[i].rdst; funct3 = 3'd0; wb_ready = 1'b1;
      #1 check($sformatf("alu%0d in_ready", i), in_ready, 1);
      @(negedge clk);
      check($sformatf("alu%0d wb_valid", i), wb_valid, 1);
      check($sformatf("alu%0d wb_data", i), wb_data, vecs[i].exp_data);
      check($sformatf("alu%0d wb_wen", i), wb_wen, vecs[i].exp_wen);
      check($sformatf("alu%0d wb_rd", i), wb_rd, vecs[i].rdst);
      in_valid = 1'b0;
    end
    @(negedge clk);
    check("alu drain wb_valid", wb_valid, 0);

    // stores
    do_store(3'd0, 32'h0000_1003, 32'h0000_00AB, 3, 4'b1000, 32'hABAB_ABAB, "SB");
    do_store(3'd1, 32'h0000_1002, 32'h1234_CAFE, 1, 4'b1100, 32'hCAFE_CAFE, "SH");
    do_store(3'd1, 32'h0000_1000, 32'h1234_CAFE, 0, 4'b0011, 32'hCAFE_CAFE, "SH0");
    do_store(3'd2, 32'h0000_1004, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344, "SW");
    do_store(3'd0, 32'h0000_1001, 32'h0000_0055, 0, 4'b0010, 32'h5555_5555, "SB1");

    // loads
    do_load(3'd0, 32'h0000_2002, 5'd6, 0, 2, 32'h0080_0000, 32'hFFFF_FF80, 1'b1, "LB");
    do_load(3'd4, 32'h0000_2002, 5'd6, 1, 2, 32'h0080_0000, 32'h0000_0080, 1'b1, "LBU");
    do_load(3'd1, 32'h0000_2002, 5'd8, 0, 0, 32'h8001_FFFF, 32'hFFFF_8001, 1'b1, "LH");
    do_load(3'd5, 32'h0000_2002, 5'd8, 0, 1, 32'h8001_FFFF, 32'h0000_8001, 1'b1, "LHU");
    do_load(3'd1, 32'h0000_2000, 5'd8, 0, 0, 32'h8001_FFFF, 32'hFFFF_FFFF, 1'b1, "LH0");
    do_load(3'd0, 32'h0000_2001, 5'd2, 2, 0, 32'h0000_7F00, 32'h0000_007F, 1'b1, "LB1");

    // WB back-pressure: hold, then drain and refill in one cycle
    in_valid = 1'b1; instr_type = TY_R; ex_result = 32'h55; rd = 5'd3; wb_ready = 1'b1;
    @(negedge clk);
    check("bp first wb_data", wb_data, 32'h55);
    instr_type = TY_R; ex_result = 32'h66; rd = 5'd4; wb_ready = 1'b0;
    #1 check("bp in_ready stall", in_ready, 0);
    @(negedge clk);
    check("bp held wb_valid", wb_valid, 1);
    check("bp held wb_data", wb_data, 32'h55);
    check("bp held wb_rd", wb_rd, 3);
    wb_ready = 1'b1;
    #1 check("bp in_ready release", in_ready, 1);
    @(negedge clk);
    check("bp refill wb_valid", wb_valid, 1);
    check("bp refill wb_data", wb_data, 32'h66);
    check("bp refill wb_rd", wb_rd, 4);

    // memory op behind a stalled WB slot must not start
    instr_type = TY_LOAD; funct3 = 3'd2; ex_result = 32'h3000; rd = 5'd0; wb_ready = 1'b0;
    #1 check("bp mem in_ready", in_ready, 0);
    @(negedge clk);
    check("bp mem state", dbg_state, 0);
    check("bp mem MemRead", MemRead, 0);
    check("bp mem wb_data", wb_data, 32'h66);
    do_load(3'd2, 32'h0000_3000, 5'd0, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "LW rd0");

    // reset while waiting for load data
    in_valid = 1'b1; instr_type = TY_LOAD; funct3 = 3'd2; ex_result = 32'h4000; rd = 5'd12;
    @(negedge clk);
    Mem_Req_Ready = 1'b1;
    @(negedge clk);
    Mem_Req_Ready = 1'b0;
    check("rstw in RD_WAIT", dbg_state, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rstw state", dbg_state, 0);
    check("rstw rd_ready", Read_data_Ready, 0);
    check("rstw wb_valid", wb_valid, 0);
    check("rstw MemRead", MemRead, 0);
`ifdef MEM_PERF_CNT_EN
    check("rstw ld_cnt", load_stall_cnt, 0);
    check("rstw st_cnt", store_stall_cnt, 0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post rst state", dbg_state, 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
